// File: rtl/sfu_accum_pkg.sv
// Shared definitions for the SFU accumulate family: FSM encoding, default
// geometry constants and the saturate / ReLU helpers reused by later variants.
package sfu_accum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int COL_DEF     = 8;
   localparam int PSUM_BW_DEF = 16;

   // Working width for the helpers; wide enough for any practical psum width,
   // callers sign-extend into it and truncate the result back.
   localparam int SAT_W = 64;

   // Clamp a signed value to the range of a bw-bit two's complement number.
   function automatic logic signed [SAT_W-1:0] sat_to(
      input logic signed [SAT_W-1:0] s,
      input int unsigned             bw
   );
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      one = 1;
      hi  = (one <<< (bw - 1)) - one;
      lo  = -hi - one;
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

   // Rectified linear unit: negative values become zero.
   function automatic logic signed [SAT_W-1:0] relu(
      input logic signed [SAT_W-1:0] x
   );
      if (x < 0)
         return '0;
      else
         return x;
   endfunction

endpackage

// File: rtl/sfu_acc_bank.sv
// Accumulator storage: DEPTH entries of one full psum vector each.
// Combinational read at any address, registered write with enable, no reset
// (the first pass of every job overwrites whatever is stored).
module sfu_acc_bank #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 128,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the saturated sum on the capture edge.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sfu_accum.sv
// Special-function / accumulate stage behind the array's output psum FIFO.
// Pops one vector at a time, accumulates it into the bank over several passes,
// and on the last pass emits the saturated, ReLU'd result.
module sfu_accum
   import sfu_accum_pkg::*;
#(
   parameter int COL     = COL_DEF,
   parameter int PSUM_BW = PSUM_BW_DEF,
   parameter int DEPTH   = 16,
   parameter int RD_LAT  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3:0]             cfg_passes,
   input  logic                   in_valid,
   input  logic [PSUM_BW*COL-1:0] in_data,
   output logic                   rd_req,
   output logic [PSUM_BW*COL-1:0] out_data,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   done
);

   localparam int VW = PSUM_BW * COL;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(RD_LAT + 1);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] addr;
   logic [3:0]    pass;
   logic [3:0]    passes;
   logic [CW-1:0] wait_cnt;

   logic          capture;
   logic          last_vec;
   logic          last_pass;

   logic [VW-1:0] acc_rdata;
   logic [VW-1:0] wr_data;
   logic [VW-1:0] relu_data;

   // The read is exactly one outstanding pop; in_data is valid on the edge
   // where the counter runs out.
   assign capture   = (state == ST_WAIT) && (wait_cnt == CW'(1));
   assign last_vec  = (addr == AW'(DEPTH - 1));
   assign last_pass = (pass == passes - 4'd1);

   // Next-state and control outputs; rd_req is a single-cycle pulse because
   // ACCUM is always left in the same cycle the pop is issued.
   always_comb begin
      state_nxt = state;
      rd_req    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start)
               state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            busy = 1'b1;
            if (in_valid) begin
               rd_req    = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (capture)
               state_nxt = (last_vec && last_pass) ? ST_DONE : ST_ACCUM;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Job bookkeeping: pass count latch, vector address, pass index, read timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         passes   <= 4'd1;
         addr     <= '0;
         pass     <= '0;
         wait_cnt <= '0;
      end else begin
         if (state == ST_IDLE && start) begin
            passes <= (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
            addr   <= '0;
            pass   <= '0;
         end
         if (state == ST_ACCUM && in_valid)
            wait_cnt <= CW'(RD_LAT);
         else if (state == ST_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - CW'(1);
         if (capture) begin
            addr <= addr + AW'(1);
            if (last_vec)
               pass <= pass + 4'd1;
         end
      end
   end

   // ---- stage 0: per-lane add, saturate and rectify (combinational) ----
   for (genvar g = 0; g < COL; g++) begin : g_lane
      logic signed [PSUM_BW-1:0] acc_l;
      logic signed [PSUM_BW-1:0] in_l;
      logic signed [PSUM_BW:0]   sum_l;
      logic signed [PSUM_BW-1:0] sat_l;

      // Pass 0 starts from zero so stale bank contents never leak in.
      assign acc_l = (pass == 4'd0) ? '0 : acc_rdata[g*PSUM_BW +: PSUM_BW];
      assign in_l  = in_data[g*PSUM_BW +: PSUM_BW];
      assign sum_l = {acc_l[PSUM_BW-1], acc_l} + {in_l[PSUM_BW-1], in_l};
      assign sat_l = PSUM_BW'(sat_to(SAT_W'(sum_l), PSUM_BW));

      assign wr_data[g*PSUM_BW +: PSUM_BW]   = sat_l;
      assign relu_data[g*PSUM_BW +: PSUM_BW] = PSUM_BW'(relu(SAT_W'(sat_l)));
   end

   sfu_acc_bank #(
      .DEPTH (DEPTH),
      .WIDTH (VW),
      .AW    (AW)
   ) u_bank (
      .clk   (clk),
      .we    (capture),
      .waddr (addr),
      .wdata (wr_data),
      .raddr (addr),
      .rdata (acc_rdata)
   );

   // ---- stage 1: registered result, emitted only on the final pass ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= capture && last_pass;
         if (capture && last_pass)
            out_data <= relu_data;
      end
   end

endmodule

// File: tb/tb_sfu_accum.sv
// Bench for sfu_accum: a small FIFO model with two-cycle read latency feeds
// the block, expected vectors go into a scoreboard queue and a monitor
// compares every out_valid against the queue head.
module tb_sfu_accum;
   import sfu_accum_pkg::*;

   localparam int COL    = 8;
   localparam int BW     = 16;
   localparam int DEPTH  = 16;
   localparam int RD_LAT = 2;
   localparam int W      = COL * BW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    cfg_passes;
   logic          in_valid;
   logic [W-1:0]  in_data = '0;
   logic          rd_req;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          busy;
   logic          done;

   sfu_accum #(
      .COL     (COL),
      .PSUM_BW (BW),
      .DEPTH   (DEPTH),
      .RD_LAT  (RD_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cfg_passes (cfg_passes),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .rd_req     (rd_req),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // FIFO model: rd_req is registered, the next edge presents the data,
   // so the DUT sees it RD_LAT edges after the request edge.
   logic [W-1:0] fifo_mem [0:1023];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   logic         rd_d1 = 1'b0;
   logic         flush = 1'b0;
   logic         gate = 1'b1;
   logic         rand_gate = 1'b0;

   assign in_valid = gate && (rd_ptr != wr_ptr);

   always @(posedge clk) begin
      rd_d1 <= rd_req;
      if (flush)
         rd_ptr <= wr_ptr;
      else if (rd_d1) begin
         in_data <= fifo_mem[rd_ptr];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      if (rand_gate)
         gate = 1'($urandom_range(0, 1));
      else
         gate = 1'b1;
   end

   // Event recorders.
   int cyc = 0;
   int rd_cycs[$];
   int done_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_req)
         rd_cycs.push_back(cyc);
      if (done)
         done_cnt <= done_cnt + 1;
   end

   // Scoreboard.
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           out_cnt = 0;

   always @(negedge clk) begin
      if (out_valid) begin
         logic [W-1:0] e;
         checks++;
         out_cnt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out got %h expected no output", out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_vec got %h expected %h", out_data, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] splat(input logic [BW-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < COL; i++)
         r[i*BW +: BW] = v;
      return r;
   endfunction

   task automatic push_in(input logic [W-1:0] v);
      fifo_mem[wr_ptr] = v;
      wr_ptr++;
   endtask

   // Runs one job from a start pulse; mid >= 0 issues a stray start that many
   // cycles in. Checks pop count, one done pulse, busy low and empty scoreboard.
   task automatic run_job(input logic [3:0] pc, input int mid, input int nvec, input string tag);
      int d0;
      int r0;
      int n;
      d0 = done_cnt;
      r0 = rd_cycs.size();
      cfg_passes = pc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 0; n < 3000; n++) begin
         start = (n == mid);
         @(negedge clk);
         if (done_cnt != d0)
            break;
      end
      start = 1'b0;
      chk({tag, "_timeout"}, W'(n < 3000), W'(1));
      repeat (4) @(negedge clk);
      chk({tag, "_done_cnt"}, W'(done_cnt - d0), W'(1));
      chk({tag, "_busy"}, W'(busy), W'(0));
      chk({tag, "_rd_cnt"}, W'(rd_cycs.size() - r0), W'(nvec));
      chk({tag, "_pending"}, W'(exp_q.size()), W'(0));
   endtask

   initial begin
      int r0;
      int bad;
      int o0;
      int n;
      int lv[8];
      int le[8];
      logic [W-1:0] v;
      logic [W-1:0] e;

      reset = 1'b1;
      start = 1'b0;
      cfg_passes = 4'd0;
      #1;
      chk("rst_rd_req", W'(rd_req), W'(0));
      chk("rst_out_data", out_data, W'(0));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1: single pass, lanes = address
      for (int a = 0; a < DEPTH; a++) begin
         push_in(splat(BW'(a)));
         exp_q.push_back(splat(BW'(a)));
      end
      r0 = rd_cycs.size();
      run_job(4'd1, -1, 16, "t1");
      bad = 0;
      for (int i = r0 + 1; i < r0 + 16; i++)
         if (rd_cycs[i] - rd_cycs[i-1] != RD_LAT + 1)
            bad++;
      chk("t1_rd_period", W'(bad), W'(0));

      // 2: three passes of 100 -> 300
      for (int i = 0; i < 3 * DEPTH; i++)
         push_in(splat(16'd100));
      for (int a = 0; a < DEPTH; a++)
         exp_q.push_back(splat(16'd300));
      run_job(4'd3, -1, 48, "t2");

      // 3a: positive saturation
      for (int i = 0; i < 2 * DEPTH; i++)
         push_in(splat(16'h7000));
      for (int a = 0; a < DEPTH; a++)
         exp_q.push_back(splat(16'h7FFF));
      run_job(4'd2, -1, 32, "t3a");

      // 3b: negative saturation then ReLU
      for (int i = 0; i < 2 * DEPTH; i++)
         push_in(splat(16'h9000));
      for (int a = 0; a < DEPTH; a++)
         exp_q.push_back(splat(16'h0000));
      run_job(4'd2, -1, 32, "t3b");

      // 4: mixed signs, one pass
      lv = '{-5, 7, 0, -32768, 32767, -1, 1, 100};
      le = '{0, 7, 0, 0, 32767, 0, 1, 100};
      for (int i = 0; i < COL; i++) begin
         v[i*BW +: BW] = BW'(lv[i]);
         e[i*BW +: BW] = BW'(le[i]);
      end
      for (int a = 0; a < DEPTH; a++) begin
         push_in(v);
         exp_q.push_back(e);
      end
      run_job(4'd1, -1, 16, "t4");

      // 5: random in_valid gaps and an ignored second start
      rand_gate = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         push_in(splat(BW'(a)));
         exp_q.push_back(splat(BW'(a)));
      end
      run_job(4'd1, 20, 16, "t5");
      rand_gate = 1'b0;

      // 6: reset after five results, then a cfg_passes=0 job
      for (int a = 0; a < DEPTH; a++) begin
         push_in(splat(16'd7));
         exp_q.push_back(splat(16'd7));
      end
      o0 = out_cnt;
      n = done_cnt;
      cfg_passes = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bad = 1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #2;
         if (out_cnt >= o0 + 5) begin
            bad = 0;
            break;
         end
      end
      chk("t6_wait5", W'(bad), W'(0));
      reset = 1'b1;
      #1;
      chk("t6_rst_out_data", out_data, W'(0));
      chk("t6_rst_out_valid", W'(out_valid), W'(0));
      chk("t6_rst_busy", W'(busy), W'(0));
      chk("t6_rst_rd_req", W'(rd_req), W'(0));
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      chk("t6_no_done", W'(done_cnt - n), W'(0));
      for (int a = 0; a < DEPTH; a++) begin
         push_in(splat(BW'(a - 8)));
         exp_q.push_back(splat(BW'((a > 8) ? a - 8 : 0)));
      end
      run_job(4'd0, -1, 16, "t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
